// File: rtl/qtree_run_ctrl.sv
// qtree_run_ctrl: run sequencer for a distilled QTree kernel.
// Collects one root pointer per input tree from the stream loader, launches the
// Go token plus every argument pointer on independent valid/ready channels,
// waits for the kernel result and presents it to the host on a held-valid
// handshake. A cycle counter supervises LAUNCH+RUN and trips a timeout.
module qtree_run_ctrl #(
    parameter int NUM_ARGS       = 2,
    parameter int PTR_W          = 17,
    parameter int RES_W          = 33,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic                      abort,
    output logic                      load_en,
    input  logic                      root_we,
    input  logic [PTR_W-1:0]          root_ptr,
    output logic                      go_d,
    input  logic                      go_r,
    output logic [NUM_ARGS*PTR_W-1:0] args_d,
    input  logic [NUM_ARGS-1:0]       args_r,
    input  logic [RES_W-1:0]          res_d,
    output logic                      res_r,
    output logic [RES_W-1:0]          result_data,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int IDX_W = $clog2(NUM_ARGS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ARGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]          state;
    logic [PTR_W-1:0]    slot [NUM_ARGS];   // captured root pointers
    logic [NUM_ARGS-1:0] arg_v;             // argument channel still offering its token
    logic                go_v;              // Go token still offered
    logic [NUM_ARGS:0]   done;              // bit 0: Go, bit k+1: argument k
    logic [IDX_W-1:0]    idx;               // next slot to fill

    logic [NUM_ARGS:0]   xfer;              // channel handshakes completing this cycle
    logic [NUM_ARGS-1:0] launch_v;          // per-slot valid flag as seen at LAUNCH entry
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;

    assign load_en = (state == S_LOAD);
    assign res_r   = (state == S_RUN);
    assign busy    = (state != S_IDLE);
    assign go_d    = go_v;

    assign cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc >= TIMEOUT_LIM);

    // Argument bus, per-channel handshakes and the valid flags a fresh launch will offer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        args_d   = '0;
        xfer     = '0;
        launch_v = '0;
        xfer[0]  = go_v & go_r;
        for (int k = 0; k < NUM_ARGS; k++) begin
            // Payload bits stay on the bus; only the valid bit drops after transfer.
            args_d[k*PTR_W +: PTR_W] = {slot[k][PTR_W-1:1], slot[k][0] & arg_v[k]};
            xfer[k+1]   = slot[k][0] & arg_v[k] & args_r[k];
            // The slot being written on the final root_we edge is not yet in slot[].
            launch_v[k] = (idx == IDX_W'(k)) ? root_ptr[0] : slot[k][0];
        end
    end

    // Run sequencer: state, pointer capture, launch tracking, result capture, supervision.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
        if (!aresetn) begin
            state        <= S_IDLE;
            go_v         <= 1'b0;
            arg_v        <= '0;
            done         <= '0;
            idx          <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            timeout_err  <= 1'b0;
            cycle_count  <= '0;
            // NOTE: the pointer slots are reset because they are visible on args_d, which must read zero out of reset.
            for (int k = 0; k < NUM_ARGS; k++) begin
                slot[k] <= '0;
            end
        end else if (abort) begin
            state        <= S_IDLE;
            go_v         <= 1'b0;
            arg_v        <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        cycle_count <= '0;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        done        <= '0;
                        go_v        <= 1'b0;
                        arg_v       <= '0;
                    end
                end
                S_LOAD: begin
                    if (root_we) begin
                        for (int k = 0; k < NUM_ARGS; k++) begin
                            if (idx == IDX_W'(k)) begin
                                slot[k] <= root_ptr;
                            end
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state <= S_LAUNCH;
                            go_v  <= 1'b1;
                            arg_v <= launch_v;
                            // A null root has no token to send, so its channel counts as done.
                            done  <= {~launch_v, 1'b0};
                        end
                    end
                end
                S_LAUNCH: begin
                    cycle_count <= cnt_inc;
                    go_v        <= go_v & ~xfer[0];
                    arg_v       <= arg_v & ~xfer[NUM_ARGS:1];
                    done        <= done | xfer;
                    if (&(done | xfer)) begin
                        state <= S_RUN;
                    end else if (timeout_hit) begin
                        state       <= S_ERROR;
                        go_v        <= 1'b0;
                        arg_v       <= '0;
                        timeout_err <= 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_count <= cnt_inc;
                    if (res_d[0]) begin
                        result_data  <= res_d;
                        result_valid <= 1'b1;
                        state        <= S_HOLD;
                    end else if (timeout_hit) begin
                        state       <= S_ERROR;
                        timeout_err <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtree_run_ctrl.sv
// Self-checking bench for qtree_run_ctrl: directed scenarios plus randomized
// runs, all predicted from a run-level timing model (per-channel ready delay,
// result delay, host delay) rather than from the controller's internals.
`timescale 1ns/1ps
module tb_qtree_run_ctrl;

    localparam int NA = 2;
    localparam int PW = 17;
    localparam int RW = 33;
    localparam int TO = 20;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              root_we = 1'b0;
    logic [PW-1:0]     root_ptr = '0;
    logic              go_r = 1'b0;
    logic [NA-1:0]     args_r = '0;
    logic [RW-1:0]     res_d = '0;
    logic              result_ready = 1'b0;

    logic              load_en;
    logic              go_d;
    logic [NA*PW-1:0]  args_d;
    logic              res_r;
    logic [RW-1:0]     result_data;
    logic              result_valid;
    logic              busy;
    logic              timeout_err;
    logic [CW-1:0]     cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qtree_run_ctrl #(
        .NUM_ARGS(NA), .PTR_W(PW), .RES_W(RW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
        .load_en(load_en), .root_we(root_we), .root_ptr(root_ptr),
        .go_d(go_d), .go_r(go_r), .args_d(args_d), .args_r(args_r),
        .res_d(res_d), .res_r(res_r), .result_data(result_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .timeout_err(timeout_err), .cycle_count(cycle_count)
    );

    // One cycle step: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Expected argument bus: stored pointers, valid bit shown only while still offered.
    function automatic logic [NA*PW-1:0] exp_args(input logic [NA*PW-1:0] roots,
                                                  input logic [NA-1:0] vmask);
        logic [NA*PW-1:0] e;
        e = roots;
        for (int k = 0; k < NA; k++) e[k*PW] = roots[k*PW] & vmask[k];
        return e;
    endfunction

    function automatic logic [NA*PW-1:0] rand_roots();
        logic [NA*PW-1:0] r;
        for (int k = 0; k < NA; k++) begin
            r[k*PW +: PW] = PW'($urandom);
            r[k*PW] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_res(input logic vbit);
        logic [63:0] t;
        logic [RW-1:0] r;
        t = {$urandom, $urandom};
        r = t[RW-1:0];
        r[0] = vbit;
        return r;
    endfunction

    // Full run: dg/da* = cycle (from LAUNCH entry) each ready rises, rdel = RUN cycles
    // before a valid result, hdel = host stall cycles, gap = idle cycles before each root.
    task automatic do_run(input string tag, input logic [NA*PW-1:0] roots,
                          input int dg, input int da0, input int da1,
                          input int rdel, input logic [RW-1:0] rval,
                          input int hdel, input int gap);
        int da [NA];
        int dmax;
        int cnt_exp;
        logic [NA-1:0] vm;
        logic [NA*PW-1:0] ea;
        da[0] = da0;
        da[1] = da1;
        dmax = dg;
        for (int k = 0; k < NA; k++) if (da[k] > dmax) dmax = da[k];
        go_r = 1'b0; args_r = '0; result_ready = 1'b0; res_d = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (load_en !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s load_entry: load_en=%b busy=%b timeout_err=%b want 1 1 0",
                     tag, load_en, busy, timeout_err);
        end

        for (int k = 0; k < NA; k++) begin
            for (int g = 0; g < gap; g++) tick();
            root_we = 1'b1;
            root_ptr = roots[k*PW +: PW];
            tick();
            root_we = 1'b0;
            checks++;
            if (load_en !== (k < NA - 1)) begin
                errors++;
                $display("FAIL %s load_en_after_root%0d: got %b want %b", tag, k, load_en, (k < NA - 1));
            end
        end

        // LAUNCH: channel c offers its token through cycle da[c] (its first ready cycle).
        for (int t = 0; t <= dmax; t++) begin
            for (int k = 0; k < NA; k++) vm[k] = (t <= da[k]);
            ea = exp_args(roots, vm);
            checks++;
            if (go_d !== (t <= dg) || args_d !== ea || res_r !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s launch_t%0d: go_d=%b args_d=%h res_r=%b busy=%b want go_d=%b args_d=%h res_r=0 busy=1",
                         tag, t, go_d, args_d, res_r, busy, (t <= dg), ea);
            end
            go_r = (t >= dg);
            for (int k = 0; k < NA; k++) args_r[k] = (t >= da[k]);
            tick();
        end

        ea = exp_args(roots, '0);
        checks++;
        if (res_r !== 1'b1 || cycle_count !== CW'(dmax + 1) || go_d !== 1'b0 || args_d !== ea) begin
            errors++;
            $display("FAIL %s run_entry: res_r=%b cycle_count=%0d go_d=%b args_d=%h want 1 %0d 0 %h",
                     tag, res_r, cycle_count, go_d, args_d, dmax + 1, ea);
        end
        go_r = 1'b0;
        args_r = '0;

        for (int i = 0; i <= rdel; i++) begin
            if (i > 0) begin
                checks++;
                if (res_r !== 1'b1 || result_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s run_wait%0d: res_r=%b result_valid=%b want 1 0", tag, i, res_r, result_valid);
                end
            end
            res_d = (i == rdel) ? rval : rand_res(1'b0);
            tick();
        end

        cnt_exp = dmax + 1 + rdel + 1;
        for (int j = 0; j <= hdel; j++) begin
            checks++;
            if (result_valid !== 1'b1 || result_data !== rval || res_r !== 1'b0 ||
                busy !== 1'b1 || cycle_count !== CW'(cnt_exp)) begin
                errors++;
                $display("FAIL %s hold%0d: result_valid=%b result_data=%h res_r=%b busy=%b cycle_count=%0d want 1 %h 0 1 %0d",
                         tag, j, result_valid, result_data, res_r, busy, cycle_count, rval, cnt_exp);
            end
            // A second valid result during HOLD must not be taken.
            res_d = rand_res(1'b1);
            result_ready = (j == hdel);
            tick();
        end
        result_ready = 1'b0;
        res_d = '0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_data !== rval || load_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done: busy=%b result_valid=%b result_data=%h load_en=%b want 0 0 %h 0",
                     tag, busy, result_valid, result_data, load_en, rval);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++;
        if (load_en !== 1'b0 || go_d !== 1'b0 || args_d !== '0 || res_r !== 1'b0 ||
            result_data !== '0 || result_valid !== 1'b0 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_state: load_en=%b go_d=%b args_d=%h res_r=%b result_data=%h result_valid=%b busy=%b timeout_err=%b cycle_count=%0d want all 0",
                     load_en, go_d, args_d, res_r, result_data, result_valid, busy, timeout_err, cycle_count);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_run("basic", {17'h00023, 17'h00015}, 0, 0, 0, 0, 33'h0000000F1, 2, 0);
    endtask

    task automatic test_stagger();
        do_run("stagger", rand_roots(), 0, 6, 3, 1, rand_res(1'b1), 0, 1);
    endtask

    task automatic test_backpressure();
        do_run("backpressure", rand_roots(), 1, 0, 2, 3, rand_res(1'b1), 10, 0);
    endtask

    task automatic test_timeout();
        logic [NA*PW-1:0] roots;
        roots = rand_roots();
        go_r = 1'b1; args_r = '1; res_d = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NA; k++) begin
            root_we = 1'b1;
            root_ptr = roots[k*PW +: PW];
            tick();
        end
        root_we = 1'b0;
        tick();   // single LAUNCH cycle: everything transfers
        for (int i = 1; i < TO; i++) begin
            checks++;
            if (res_r !== 1'b1 || cycle_count !== CW'(i) || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_run%0d: res_r=%b cycle_count=%0d timeout_err=%b want 1 %0d 0",
                         i, res_r, cycle_count, timeout_err, i);
            end
            res_d = rand_res(1'b0);
            tick();
        end
        checks++;
        if (timeout_err !== 1'b1 || cycle_count !== CW'(TO) || busy !== 1'b1 || res_r !== 1'b0 ||
            go_d !== 1'b0 || args_d !== exp_args(roots, '0) || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error_entry: timeout_err=%b cycle_count=%0d busy=%b res_r=%b go_d=%b args_d=%h result_valid=%b want 1 %0d 1 0 0 %h 0",
                     timeout_err, cycle_count, busy, res_r, go_d, args_d, result_valid, TO, exp_args(roots, '0));
        end
        go_r = 1'b0; args_r = '0; res_d = '0;
        start = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b1 || load_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error_stays: busy=%b timeout_err=%b load_en=%b want 1 1 0", busy, timeout_err, load_en);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b timeout_err=%b want 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_abort();
        logic [NA*PW-1:0] roots;
        roots = rand_roots();
        go_r = 1'b1; args_r = '1; args_r[0] = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NA; k++) begin
            root_we = 1'b1;
            root_ptr = roots[k*PW +: PW];
            tick();
        end
        root_we = 1'b0;
        tick();   // second LAUNCH cycle: only argument 0 still offered
        checks++;
        if (go_d !== 1'b0 || args_d !== exp_args(roots, NA'(1)) || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: go_d=%b args_d=%h busy=%b want 0 %h 1", go_d, args_d, busy, exp_args(roots, NA'(1)));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        go_r = 1'b0; args_r = '0;
        checks++;
        if (busy !== 1'b0 || go_d !== 1'b0 || args_d !== exp_args(roots, '0) || res_r !== 1'b0 || load_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_launch: busy=%b go_d=%b args_d=%h res_r=%b load_en=%b want 0 0 %h 0 0",
                     busy, go_d, args_d, res_r, load_en, exp_args(roots, '0));
        end
        do_run("after_abort", rand_roots(), 2, 1, 0, 0, rand_res(1'b1), 1, 0);
    endtask

    task automatic test_midrun_reset();
        logic [NA*PW-1:0] roots;
        roots = rand_roots();
        go_r = 1'b1; args_r = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NA; k++) begin
            root_we = 1'b1;
            root_ptr = roots[k*PW +: PW];
            tick();
        end
        root_we = 1'b0;
        repeat (3) tick();   // LAUNCH, then two RUN cycles
        go_r = 1'b0; args_r = '0;
        aresetn = 1'b0;
        tick();
        checks++;
        if (load_en !== 1'b0 || go_d !== 1'b0 || args_d !== '0 || res_r !== 1'b0 ||
            result_data !== '0 || result_valid !== 1'b0 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL midrun_reset: load_en=%b go_d=%b args_d=%h res_r=%b result_data=%h result_valid=%b busy=%b timeout_err=%b cycle_count=%0d want all 0",
                     load_en, go_d, args_d, res_r, result_data, result_valid, busy, timeout_err, cycle_count);
        end
        aresetn = 1'b1;
        root_we = 1'b1;
        root_ptr = 17'h1ABCD;
        tick();
        root_we = 1'b0;
        checks++;
        if (busy !== 1'b0 || load_en !== 1'b0 || args_d !== '0) begin
            errors++;
            $display("FAIL idle_root_we: busy=%b load_en=%b args_d=%h want 0 0 0", busy, load_en, args_d);
        end
        do_run("after_reset", rand_roots(), 0, 0, 0, 2, rand_res(1'b1), 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            do_run($sformatf("random%0d", n), rand_roots(),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 5)), rand_res(1'b1),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stagger();
        test_backpressure();
        test_timeout();
        test_abort();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
